// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: FSM state encoding and port indices.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational two-way round-robin selector: on a tie the port that did not
// own the bus last time wins.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       sel
);

  // Winner selection from the current request vector
  always_comb begin
    valid = 1'b0;
    sel   = PORT_CPU;
    case (req)
      2'b01: begin
        valid = 1'b1;
        sel   = PORT_CPU;
      end
      2'b10: begin
        valid = 1'b1;
        sel   = PORT_AUX;
      end
      2'b11: begin
        valid = 1'b1;
        sel   = ~last;
      end
      default: begin
        valid = 1'b0;
        sel   = PORT_CPU;
      end
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port memory bus arbiter: round-robin grant, strobed access with bounded
// wait for mem_ready, one-cycle done/err pulse and per-port read data hold.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_done,
  output logic                  m0_err,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_done,
  output logic                  m1_err,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_read,
  output logic                  mem_write,
  input  logic                  mem_ready,
  output logic                  busy,
  output logic                  owner
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  last_q, last_d;
  logic                  owner_q, owner_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [1:0]            gnt_q, gnt_d;
  logic [1:0]            done_q, done_d;
  logic [1:0]            err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic                  busy_q, busy_d;

  logic                  pick_valid_s;
  logic                  pick_sel_s;
  logic                  sel_we_s;
  logic [ADDR_WIDTH-1:0] sel_addr_s;
  logic [DATA_WIDTH-1:0] sel_wdata_s;

  rr_pick2 u_pick (
    .req   ({m1_req, m0_req}),
    .last  (last_q),
    .valid (pick_valid_s),
    .sel   (pick_sel_s)
  );

  // Route the winning port's request fields toward the latch registers
  always_comb begin
    if (pick_sel_s == PORT_AUX) begin
      sel_we_s    = m1_we;
      sel_addr_s  = m1_addr;
      sel_wdata_s = m1_wdata;
    end else begin
      sel_we_s    = m0_we;
      sel_addr_s  = m0_addr;
      sel_wdata_s = m0_wdata;
    end
  end

  // Next-state and next-output computation; pulses default low every cycle
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    gnt_d    = 2'b00;
    done_d   = 2'b00;
    err_d    = 2'b00;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    busy_d   = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid_s) begin
          state_d           = ST_ACCESS;
          cnt_d             = CNT_ZERO;
          last_d            = pick_sel_s;
          owner_d           = pick_sel_s;
          we_d              = sel_we_s;
          addr_d            = sel_addr_s;
          wdata_d           = sel_wdata_s;
          gnt_d[pick_sel_s] = 1'b1;
          rd_d              = ~sel_we_s;
          wr_d              = sel_we_s;
          busy_d            = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        // A ready on the final counted cycle still completes successfully
        if (mem_ready || (cnt_q == CNT_LAST)) begin
          state_d         = ST_RESP;
          rd_d            = 1'b0;
          wr_d            = 1'b0;
          done_d[owner_q] = 1'b1;
          err_d[owner_q]  = ~mem_ready;
          if (mem_ready && !we_q) begin
            if (owner_q == PORT_AUX) begin
              rdata1_d = mem_rdata;
            end else begin
              rdata0_d = mem_rdata;
            end
          end else begin
            rdata0_d = rdata0_q;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= CNT_ZERO;
      last_q   <= PORT_AUX;
      owner_q  <= PORT_CPU;
      we_q     <= 1'b0;
      addr_q   <= {ADDR_WIDTH{1'b0}};
      wdata_q  <= {DATA_WIDTH{1'b0}};
      gnt_q    <= 2'b00;
      done_q   <= 2'b00;
      err_q    <= 2'b00;
      rdata0_q <= {DATA_WIDTH{1'b0}};
      rdata1_q <= {DATA_WIDTH{1'b0}};
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      busy_q   <= busy_d;
    end
  end

  assign m0_gnt    = gnt_q[0];
  assign m1_gnt    = gnt_q[1];
  assign m0_done   = done_q[0];
  assign m1_done   = done_q[1];
  assign m0_err    = err_q[0];
  assign m1_err    = err_q[1];
  assign m0_rdata  = rdata0_q;
  assign m1_rdata  = rdata1_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_read  = rd_q;
  assign mem_write = wr_q;
  assign busy      = busy_q;
  assign owner     = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; inputs driven and outputs sampled on the falling edge.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [19:0] m0_addr, m1_addr;
  logic [15:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err;
  logic [15:0] m0_rdata, m1_rdata;
  logic [19:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic        mem_read, mem_write, mem_ready, busy, owner;

  int errors = 0;
  int checks = 0;

  // Values observed by do_access
  int          obs_gnt_cyc, obs_done_cyc, obs_strobes;
  logic        obs_err;
  logic [19:0] obs_addr;
  logic [15:0] obs_wdata;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_ready(mem_ready),
    .busy(busy), .owner(owner)
  );

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drive one access on a port; mem_ready is raised during ACCESS cycle ready_cyc (0 = never).
  task automatic do_access(input int port, input logic we, input logic [19:0] addr,
                           input logic [15:0] wdata, input int ready_cyc, input logic [15:0] rd);
    obs_gnt_cyc = -1; obs_done_cyc = -1; obs_strobes = 0; obs_err = 1'b0;
    obs_addr = 20'h0; obs_wdata = 16'h0;
    if (port == 0) begin
      m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wdata;
    end else begin
      m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wdata;
    end
    for (int c = 1; c <= 40; c++) begin
      cyc();
      mem_ready = 1'b0;
      if ((port == 0 && m0_gnt) || (port == 1 && m1_gnt)) begin
        obs_gnt_cyc = c;
        m0_req = 1'b0;
        m1_req = 1'b0;
      end
      if (mem_read || mem_write) begin
        if (obs_strobes == 0) begin
          obs_addr = mem_addr;
          obs_wdata = mem_wdata;
        end
        obs_strobes++;
      end
      if ((port == 0 && m0_done) || (port == 1 && m1_done)) begin
        obs_done_cyc = c;
        obs_err = (port == 0) ? m0_err : m1_err;
        break;
      end
      if (c == ready_cyc) begin
        mem_ready = 1'b1;
        mem_rdata = rd;
      end
    end
    mem_ready = 1'b0;
    m0_req = 1'b0;
    m1_req = 1'b0;
    if (obs_done_cyc < 0) begin
      checks++; errors++;
      $display("FAIL access_timeout_bound: no done seen within 40 cycles (port %0d)", port);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = 20'h0; m0_wdata = 16'h0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = 20'h0; m1_wdata = 16'h0;
    mem_rdata = 16'h0; mem_ready = 1'b0;
    repeat (2) cyc();
    checks++;
    if ({m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err, mem_read, mem_write, busy, owner} !== 10'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 0", {m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err, mem_read, mem_write, busy, owner});
    end
    checks++;
    if ({m0_rdata, m1_rdata, mem_addr, mem_wdata} !== 68'h0) begin
      errors++;
      $display("FAIL reset_data: got %h want 0", {m0_rdata, m1_rdata, mem_addr, mem_wdata});
    end
    reset_n = 1'b1;
    cyc();
  endtask

  task automatic test_read_p0();
    do_access(0, 1'b0, 20'h00010, 16'h0, 3, 16'hBEEF);
    checks++;
    if (obs_gnt_cyc !== 1) begin errors++; $display("FAIL read_gnt_cycle: got %0d want 1", obs_gnt_cyc); end
    checks++;
    if (obs_strobes !== 3) begin errors++; $display("FAIL read_strobe_width: got %0d want 3", obs_strobes); end
    checks++;
    if (obs_addr !== 20'h00010) begin errors++; $display("FAIL read_addr: got %h want 00010", obs_addr); end
    checks++;
    if (obs_done_cyc !== 4 || obs_err !== 1'b0) begin
      errors++; $display("FAIL read_done: got cyc %0d err %b want 4/0", obs_done_cyc, obs_err);
    end
    checks++;
    if (m0_rdata !== 16'hBEEF) begin errors++; $display("FAIL read_rdata: got %h want beef", m0_rdata); end
    checks++;
    if (mem_read !== 1'b0 || busy !== 1'b1 || owner !== 1'b0) begin
      errors++; $display("FAIL read_resp_state: got rd %b busy %b owner %b want 0/1/0", mem_read, busy, owner);
    end
    cyc();
    checks++;
    if (busy !== 1'b0 || m0_done !== 1'b0) begin
      errors++; $display("FAIL read_idle: got busy %b done %b want 0/0", busy, m0_done);
    end
  endtask

  task automatic test_write_p1();
    do_access(1, 1'b1, 20'hFFFFF, 16'h1234, 1, 16'hFFFF);
    checks++;
    if (obs_strobes !== 1 || mem_read !== 1'b0) begin
      errors++; $display("FAIL write_strobe_width: got %0d want 1", obs_strobes);
    end
    checks++;
    if (obs_addr !== 20'hFFFFF || obs_wdata !== 16'h1234) begin
      errors++; $display("FAIL write_bus: got %h/%h want fffff/1234", obs_addr, obs_wdata);
    end
    checks++;
    if (obs_done_cyc !== 2 || obs_err !== 1'b0 || owner !== 1'b1) begin
      errors++; $display("FAIL write_done: got cyc %0d err %b owner %b want 2/0/1", obs_done_cyc, obs_err, owner);
    end
    checks++;
    if (m1_rdata !== 16'h0 || m0_rdata !== 16'hBEEF) begin
      errors++; $display("FAIL write_rdata_hold: got %h/%h want 0000/beef", m1_rdata, m0_rdata);
    end
    cyc();
  endtask

  task automatic test_timeout();
    do_access(0, 1'b0, 20'h00123, 16'h0, 0, 16'h0);
    checks++;
    if (obs_strobes !== 15) begin errors++; $display("FAIL timeout_strobe_width: got %0d want 15", obs_strobes); end
    checks++;
    if (obs_done_cyc !== 16 || obs_err !== 1'b1) begin
      errors++; $display("FAIL timeout_done: got cyc %0d err %b want 16/1", obs_done_cyc, obs_err);
    end
    checks++;
    if (m0_rdata !== 16'hBEEF || m1_done !== 1'b0 || m1_err !== 1'b0) begin
      errors++; $display("FAIL timeout_hold: got rdata %h m1 %b%b want beef/00", m0_rdata, m1_done, m1_err);
    end
    cyc();
    checks++;
    if (m0_err !== 1'b0 || m0_done !== 1'b0) begin
      errors++; $display("FAIL timeout_err_pulse: got done %b err %b want 0/0", m0_done, m0_err);
    end
  endtask

  task automatic test_ready_on_timeout();
    do_access(0, 1'b0, 20'h00456, 16'h0, 15, 16'h5A5A);
    checks++;
    if (obs_strobes !== 15 || obs_done_cyc !== 16) begin
      errors++; $display("FAIL edge_timing: got strobes %0d done %0d want 15/16", obs_strobes, obs_done_cyc);
    end
    checks++;
    if (obs_err !== 1'b0 || m0_rdata !== 16'h5A5A) begin
      errors++; $display("FAIL edge_result: got err %b rdata %h want 0/5a5a", obs_err, m0_rdata);
    end
    cyc();
  endtask

  task automatic test_back_to_back();
    int gcyc[$];
    int gport[$];
    reset_n = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 20'h00AAA;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 20'h00BBB; m1_wdata = 16'h7777;
    mem_ready = 1'b1; mem_rdata = 16'h0C0C;
    cyc();
    reset_n = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      cyc();
      if (m0_gnt) begin gcyc.push_back(c); gport.push_back(0); end
      if (m1_gnt) begin gcyc.push_back(c); gport.push_back(1); end
    end
    m0_req = 1'b0; m1_req = 1'b0; mem_ready = 1'b0;
    checks++;
    if (gcyc.size() !== 4) begin
      errors++; $display("FAIL b2b_count: got %0d grants want 4", gcyc.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (gcyc[i] !== 1 + 3 * i || gport[i] !== (i % 2)) begin
          errors++;
          $display("FAIL b2b_grant%0d: got cyc %0d port %0d want %0d/%0d", i, gcyc[i], gport[i], 1 + 3 * i, i % 2);
        end
      end
    end
    repeat (3) cyc();
  endtask

  task automatic test_reset_mid_access();
    int dones;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 20'h00777;
    cyc();
    m0_req = 1'b0;
    cyc();
    cyc();
    checks++;
    if (mem_read !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL midrst_pre: got rd %b busy %b want 1/1", mem_read, busy);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (mem_read !== 1'b0 || busy !== 1'b0 || mem_addr !== 20'h0) begin
      errors++; $display("FAIL midrst_async: got rd %b busy %b addr %h want 0/0/0", mem_read, busy, mem_addr);
    end
    m0_req = 1'b1; m1_req = 1'b1; m1_we = 1'b1;
    dones = 0;
    @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      if (m0_done || m1_done) dones++;
      cyc();
    end
    reset_n = 1'b1;
    cyc();
    checks++;
    if (dones !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d done pulses want 0", dones); end
    checks++;
    if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
      errors++; $display("FAIL midrst_first_gnt: got m0 %b m1 %b want 1/0", m0_gnt, m1_gnt);
    end
    m0_req = 1'b0; m1_req = 1'b0; mem_ready = 1'b1;
    repeat (3) cyc();
    mem_ready = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    @(negedge clk);
    test_reset();
    test_read_p0();
    test_write_p1();
    test_timeout();
    test_ready_on_timeout();
    test_back_to_back();
    test_reset_mid_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port memory bus arbiter that shares the single external memory bus between the pipelined CPU (port 0) and a secondary requester such as a DMA or debug loader (port 1). It sits between the requesters and the memory interface. It serialises accesses with round-robin fairness, drives the memory strobes, waits for the memory acknowledge with a bounded timeout, and returns read data with a one-cycle completion pulse.

## Interface
- ADDR_WIDTH, 20, memory address width
- DATA_WIDTH, 16, memory data width
- TIMEOUT, 15, maximum ACCESS cycles without `mem_ready` before an error response (≥1)

One clock. Reset is asynchronous and active-low.

- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- mN_req  in  1  port N (N=0,1) request, held high until `mN_done`
- mN_we  in  1  port N: 1 = write, 0 = read
- mN_addr  in  ADDR_WIDTH  port N address
- mN_wdata  in  DATA_WIDTH  port N write data
- mN_gnt  out  1  one-cycle pulse: port N request accepted, inputs latched
- mN_done  out  1  one-cycle pulse: port N access complete
- mN_err  out  1  valid with `mN_done`: access timed out
- mN_rdata  out  DATA_WIDTH  read data, stable from `mN_done` until the next `mN_done`
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data, valid with `mem_ready`
- mem_read  out  1  read strobe, high throughout ACCESS of a read
- mem_write  out  1  write strobe, high throughout ACCESS of a write
- mem_ready  in  1  memory acknowledge
- busy  out  1  high in ACCESS and RESP
- owner  out  1  index of the current or most recent owner

## Operation
- FSM with three states:
  - IDLE → ACCESS: taken when either `mN_req` is high.
  - ACCESS → RESP: taken on `mem_ready`, or on timeout.
  - RESP → IDLE: unconditional.
- Arbitration in IDLE:
  - With a single request, that port wins.
  - With both requests, the port ≠ `last_owner` wins.
  - `last_owner` and `owner` update on the grant.
- Grant:
  - Winner's `we`, `addr` and `wdata` are latched into registers.
  - `mN_gnt` is high for exactly the first ACCESS cycle.
- ACCESS:
  - `mem_addr` and `mem_wdata` are driven from the latched registers.
  - Exactly one of `mem_read`/`mem_write` is high.
  - Wait counter starts at 0 and increments each ACCESS cycle.
- Completion:
  - `mem_ready` in any ACCESS cycle, including the first: on a read, `mem_rdata` is captured into the owner's `rdata`. Go to RESP with err = 0.
  - Counter == TIMEOUT-1 without `mem_ready`: go to RESP with err = 1 and `rdata` unchanged.
  - `mem_ready` on the timeout cycle counts as success.
- RESP:
  - Owner's `mN_done` is pulsed for one cycle, with `mN_err` as determined above.
  - All strobes are low.
- `mN_req` is sampled only in IDLE. Deasserting it during ACCESS or RESP does not abort the transfer.
- `mem_ready` outside ACCESS is ignored.
- The non-owner's outputs are unchanged throughout.
- Reset values:
  - All outputs 0.
  - `mem_addr`, `mem_wdata` and both `rdata` = 0.
  - State IDLE, counter 0.
  - `last_owner` = 1, so port 0 (CPU) wins the first tie.
- Reset mid-operation: all outputs clear immediately (asynchronously). No `done` is issued for the aborted access.

## Timing
- All outputs are registered (Moore) and change on rising `clk` only, except under reset.
- Latency, with requests sampled in IDLE at cycle 0:
  - Cycle 1: `gnt` and strobes rise.
  - Cycle k (k ≥ 1): `mem_ready` is seen.
  - Cycle k+1: `done` is high and strobes are low.
  - Cycle k+2: IDLE, able to sample new requests.
- Minimum 3 cycles per access; worst case TIMEOUT+2.
- Strobe width equals the number of ACCESS cycles (1 to TIMEOUT).
- Back-to-back requests that are both held high alternate owners: 0, 1, 0, 1.

## Structure
- Shared package `mem_arb_pkg`: state enum (`ST_IDLE`, `ST_ACCESS`, `ST_RESP`), port index constants (`PORT_CPU` = 0, `PORT_AUX` = 1).
- Sub-module `rr_pick2`: combinational 2-way round-robin selector.
  - Inputs: `req[1:0]`, `last`.
  - Outputs: `valid`, `sel`.
- Counter width is $clog2(TIMEOUT+1).
- The top level owns tristating of the inout data bus; this block uses split `mem_wdata`/`mem_rdata`.

## Test plan
- Port-0 read only, addr 0x00010; `mem_ready` in the 3rd ACCESS cycle with `mem_rdata` = 0xBEEF → `m0_gnt` at cycle 1, `mem_read` high for 3 cycles, `m0_done` with `m0_rdata` = 0xBEEF and `m0_err` = 0.
- Both ports request continuously from reset release, `mem_ready` immediate → grants 0, 1, 0, 1, each access 3 cycles apart.
- Port-1 write, addr 0xFFFFF, data 0x1234, `mem_ready` in first ACCESS cycle → `mem_write` high for exactly 1 cycle with `mem_addr` = 0xFFFFF and `mem_wdata` = 0x1234; `m1_done` next cycle.
- No `mem_ready`, TIMEOUT = 15, port-0 read → `mem_read` high for 15 cycles, then `m0_done` = `m0_err` = 1 and `m0_rdata` unchanged.
- `mem_ready` with data 0x5A5A arrives exactly on the 15th ACCESS cycle → `m0_err` = 0 and `m0_rdata` = 0x5A5A.
- `reset_n` low mid-ACCESS, then both ports request → strobes and `busy` drop immediately with no `done`; after release, port 0 is granted first.
